cpu_inta_sequencer: RTL and testbench
=====================================

Name: cpu_inta_sequencer

Overview:
- CPU-side counterpart of the PIC interrupt logic.
- Watches the PIC's INT output. When interrupts are enabled, it drives the two-pulse active-low INTA acknowledge sequence.
- Captures the 8-bit vector ({TReg, interruptLocation}) the PIC places on the data bus after the second INTA pulse.
- Hands the vector to the CPU core over a valid/ready handshake. The block sits between the CPU core and the PIC pins.

Parameters:
- INTA_LOW_CYCLES, 2, clk cycles each INTA pulse is held low (>=1).
- INTA_GAP_CYCLES, 2, clk cycles INTA is high between the two pulses (>=1).
- VECTOR_WIDTH, 8, width of the data bus and vector.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- INT  input  1  interrupt request from the PIC, active high.
- intEnable  input  1  CPU interrupt flag; 0 blocks starting a new sequence.
- dataBus  input  VECTOR_WIDTH  PIC internal/data bus carrying the vector.
- vectorReady  input  1  core accepts the vector when high together with vectorValid.
- INTA  output  1  interrupt acknowledge to the PIC, active low.
- vector  output  VECTOR_WIDTH  captured interrupt vector.
- vectorValid  output  1  vector holds an unconsumed value.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: INTA=1, vector=0, vectorValid=0, busy=0, state=IDLE, counter=0.
- Reset asserted mid-sequence: INTA returns high on the next edge, and any captured vector is discarded.
- All outputs are registered. One down-counter is sized to max(INTA_LOW_CYCLES, INTA_GAP_CYCLES).
- FSM states: IDLE, ACK1, GAP, ACK2, HOLD.
- IDLE -> ACK1: when intReq && intEnable at an edge. intReq is INT itself (or its synchronised copy, see Optional Feature). INTA goes low at that edge; counter loads INTA_LOW_CYCLES-1.
- ACK1: INTA=0. At counter==0 -> GAP, INTA=1, counter loads INTA_GAP_CYCLES-1.
- GAP: INTA=1. At counter==0 -> ACK2, INTA=0, counter loads INTA_LOW_CYCLES-1.
- ACK2: INTA=0. At counter==0 the edge captures dataBus into vector, sets vectorValid=1, sets INTA=1, and moves to HOLD.
- HOLD: vector is stable. vectorValid && vectorReady at an edge -> vectorValid=0, state IDLE.
- HOLD: no new sequence starts while vectorValid=1, even if INT is high.
- INT dropping during ACK1/GAP/ACK2 is ignored. The PIC clears INT after the first INTA by design, and the sequence always completes.
- intEnable falling after leaving IDLE does not abort the sequence.
- Total latency from the edge accepting the request to vectorValid=1 is 2*INTA_LOW_CYCLES+INTA_GAP_CYCLES cycles.
- vectorReady already high on the first HOLD cycle gives a one-cycle vectorValid pulse. The earliest restart is the cycle after returning to IDLE.
- vector holds its last captured value until the next capture; it is not cleared on consume.

Optional Feature:
- Macro INT_SYNC_EN.
- Defined: INT passes through a 2-flop synchroniser (reset to 0) before the FSM, so intReq is INT delayed 2 cycles. Request-to-first-INTA latency grows by 2 cycles.
- Undefined: intReq = INT directly, with no added latency. INT must then be synchronous to clk.

Decomposition:
- Shared package pic_pkg: state enum type (IDLE, ACK1, GAP, ACK2, HOLD), VECTOR_WIDTH default, and localparam INTA_ASSERTED = 1'b0.
- One natural sub-module: sync_2ff (generic 2-flop synchroniser), instantiated only under INT_SYNC_EN.

Test Plan:
- Basic acknowledge (macro undefined, defaults): INT=1, intEnable=1 accepted at edge k; dataBus=8'hA5.
  - INTA low for cycles k..k+1, high k+2..k+3, low k+4..k+5.
  - vector=8'hA5 and vectorValid=1 from the edge ending cycle k+5; busy high throughout.
- Masking: intEnable=0, INT=1 for 20 cycles -> INTA stays 1, busy=0. Raising intEnable then starts the sequence at the next edge.
- Handshake backpressure: vectorReady=0 for 5 cycles after capture, INT held high -> vectorValid stays 1, vector stable, no third INTA pulse. vectorReady=1 -> vectorValid clears, and a new sequence starts on a following edge.
- INT drop mid-sequence: INT falls one cycle into ACK1 -> both pulses still issued and dataBus=8'h47 captured.
- Reset mid-sequence: reset asserted during GAP -> next edge INTA=1, vectorValid=0, vector=0, busy=0. No second pulse follows after reset releases with INT=0.
- INT_SYNC_EN defined: same stimulus as the basic acknowledge case -> first INTA low occurs exactly 2 cycles later than without the macro.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the CPU-side interrupt acknowledge logic.
package pic_pkg;

  // Acknowledge sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD
  } inta_state_t;

  localparam int unsigned DEFAULT_VECTOR_WIDTH = 8;

  // INTA is an active-low strobe.
  localparam logic INTA_ASSERTED = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_inta_sequencer.sv
// CPU-side interrupt acknowledge sequencer: issues the two-pulse active-low INTA
// sequence to the PIC, captures the vector after the second pulse and offers it
// to the core over a valid/ready handshake.
// Build option: define INT_SYNC_EN to pass INT through a 2-flop synchroniser
// (adds 2 cycles of request latency). Without it INT must be synchronous to clk.
module cpu_inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES = 2,
  parameter int unsigned INTA_GAP_CYCLES = 2,
  parameter int unsigned VECTOR_WIDTH    = DEFAULT_VECTOR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    INT,
  input  logic                    intEnable,
  input  logic [VECTOR_WIDTH-1:0] dataBus,
  input  logic                    vectorReady,
  output logic                    INTA,
  output logic [VECTOR_WIDTH-1:0] vector,
  output logic                    vectorValid,
  output logic                    busy
);

  localparam int unsigned CNT_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                    INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);

  inta_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             intReq;

`ifdef INT_SYNC_EN
  sync_2ff #(
    .WIDTH (1)
  ) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (INT),
    .q     (intReq)
  );
`else
  assign intReq = INT;
`endif

  // Sequencer FSM; every output is a register updated on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      INTA        <= ~INTA_ASSERTED;
      vector      <= '0;
      vectorValid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (intReq && intEnable) begin
            state <= ACK1;
            INTA  <= INTA_ASSERTED;
            cnt   <= LOW_LOAD;
            busy  <= 1'b1;
          end
        end
        ACK1: begin
          if (cnt == '0) begin
            state <= GAP;
            INTA  <= ~INTA_ASSERTED;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= ACK2;
            INTA  <= INTA_ASSERTED;
            cnt   <= LOW_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK2: begin
          if (cnt == '0) begin
            state       <= HOLD;
            INTA        <= ~INTA_ASSERTED;
            vector      <= dataBus;
            vectorValid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          // vector is left untouched on consume; only the valid flag drops.
          if (vectorValid && vectorReady) begin
            state       <= IDLE;
            vectorValid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          INTA  <= ~INTA_ASSERTED;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Self-checking bench for cpu_inta_sequencer (default parameters). Works with or
// without INT_SYNC_EN defined; the reference model adds the request delay itself.
module tb_cpu_inta_sequencer;

  localparam int L     = 2;
  localparam int G     = 2;
  localparam int W     = 8;
  localparam int TOTAL = 2 * L + G;
`ifdef INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         INT;
  logic         intEnable;
  logic [W-1:0] dataBus;
  logic         vectorReady;
  logic         INTA;
  logic [W-1:0] vector;
  logic         vectorValid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sequence is "active" for TOTAL cycles after acceptance,
  // then the vector is pending until consumed.
  bit           m_active;
  int           m_t;
  bit           m_valid;
  logic [W-1:0] m_vector;
  bit           req_q[$];

  cpu_inta_sequencer #(
    .INTA_LOW_CYCLES (L),
    .INTA_GAP_CYCLES (G),
    .VECTOR_WIDTH    (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .INT         (INT),
    .intEnable   (intEnable),
    .dataBus     (dataBus),
    .vectorReady (vectorReady),
    .INTA        (INTA),
    .vector      (vector),
    .vectorValid (vectorValid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic exp_inta();
    return !(m_active && (m_t < L || m_t >= L + G));
  endfunction

  function automatic logic exp_busy();
    return m_active || m_valid;
  endfunction

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    bit req;
    @(posedge clk);
    if (reset) begin
      m_active = 0;
      m_t      = 0;
      m_valid  = 0;
      m_vector = '0;
      req_q.delete();
      for (int i = 0; i < SYNC_LAT; i++) req_q.push_back(1'b0);
    end else begin
      if (SYNC_LAT == 0) begin
        req = INT;
      end else begin
        req_q.push_back(INT);
        req = req_q.pop_front();
      end
      if (m_active) begin
        if (m_t == TOTAL - 1) begin
          m_active = 0;
          m_valid  = 1;
          m_vector = dataBus;
        end else begin
          m_t++;
        end
      end else if (m_valid) begin
        if (vectorReady) m_valid = 0;
      end else if (req && intEnable) begin
        m_active = 1;
        m_t      = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    INT = 0; intEnable = 0; dataBus = '0; vectorReady = 0;
    do_reset();
    n_checks++;
    if (INTA !== 1'b1 || vector !== '0 || vectorValid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: INTA=%b vector=%h valid=%b busy=%b, required 1 00 0 0",
               INTA, vector, vectorValid, busy);
    end
  endtask

  task automatic test_basic();
    logic inta_log[16];
    logic valid_log[16];
    logic busy_log[16];
    logic exp_i[7];
    logic exp_v[7];
    int   f;
    exp_i = '{0, 0, 1, 1, 0, 0, 1};
    exp_v = '{0, 0, 0, 0, 0, 0, 1};
    INT = 1; intEnable = 1; dataBus = 8'hA5; vectorReady = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      inta_log[i]  = INTA;
      valid_log[i] = vectorValid;
      busy_log[i]  = busy;
    end
    f = -1;
    for (int i = 15; i >= 0; i--) if (inta_log[i] === 1'b0) f = i;
    n_checks++;
    if (f != SYNC_LAT) begin
      n_fail++;
      $display("FAIL basic_first_inta: first low after edge %0d, required %0d", f, SYNC_LAT);
    end
    if (f >= 0 && f + 6 < 16) begin
      for (int j = 0; j < 7; j++) begin
        n_checks++;
        if (inta_log[f+j] !== exp_i[j] || valid_log[f+j] !== exp_v[j] ||
            busy_log[f+j] !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_cycle_k+%0d: INTA=%b valid=%b busy=%b, required %b %b 1",
                   j, inta_log[f+j], valid_log[f+j], busy_log[f+j], exp_i[j], exp_v[j]);
        end
      end
    end
    n_checks++;
    if (vector !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_vector: vector=%h, required a5", vector);
    end
  endtask

  // Continues from test_basic: vector pending, INT still high.
  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      dataBus = W'($urandom);
      tick();
      n_checks++;
      if (vectorValid !== 1'b1 || vector !== 8'hA5 || INTA !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: valid=%b vector=%h INTA=%b, required 1 a5 1",
                 i, vectorValid, vector, INTA);
      end
    end
    vectorReady = 1;
    tick();
    vectorReady = 0;
    n_checks++;
    if (vectorValid !== 1'b0 || busy !== 1'b0 || vector !== 8'hA5) begin
      n_fail++;
      $display("FAIL backpressure_consume: valid=%b busy=%b vector=%h, required 0 0 a5",
               vectorValid, busy, vector);
    end
    tick();
    n_checks++;
    if (INTA !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_restart: INTA=%b busy=%b, required 0 1", INTA, busy);
    end
    INT = 0;
    do_reset();
  endtask

  task automatic test_masking();
    int bad;
    bad = 0;
    INT = 1; intEnable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (INTA !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL masking_cycle_%0d: INTA=%b busy=%b, required 1 0", i, INTA, busy);
      end
    end
    intEnable = 1;
    tick();
    n_checks++;
    if (INTA !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL masking_release: INTA=%b busy=%b, required 0 1", INTA, busy);
    end
    INT = 0;
    do_reset();
  endtask

  task automatic test_int_drop();
    int   pulses;
    int   n;
    logic prev;
    INT = 1; intEnable = 1; dataBus = 8'h47; vectorReady = 0;
    n = 0;
    while (INTA !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    pulses = (INTA === 1'b0) ? 1 : 0;
    prev = INTA;
    tick();
    INT = 0;
    n = 0;
    while (vectorValid !== 1'b1 && n < 20) begin
      if (prev === 1'b1 && INTA === 1'b0) pulses++;
      prev = INTA;
      tick();
      n++;
    end
    n_checks++;
    if (vectorValid !== 1'b1 || pulses != 2 || vector !== 8'h47) begin
      n_fail++;
      $display("FAIL int_drop: valid=%b pulses=%0d vector=%h, required 1 2 47",
               vectorValid, pulses, vector);
    end
    vectorReady = 1;
    tick();
    vectorReady = 0;
  endtask

  // Continues from test_int_drop without reset so vector still holds 47.
  task automatic test_reset_mid();
    int n;
    int lows;
    INT = 1; intEnable = 1; dataBus = 8'h3C;
    n = 0;
    while (INTA !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    tick();
    INT = 0;
    n_checks++;
    if (INTA !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_in_gap: INTA=%b busy=%b, required 1 1", INTA, busy);
    end
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (INTA !== 1'b1 || vectorValid !== 1'b0 || vector !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: INTA=%b valid=%b vector=%h busy=%b, required 1 0 00 0",
               INTA, vectorValid, vector, busy);
    end
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (INTA !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_resume: %0d active cycles after reset, required 0", lows);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      INT         = ($urandom_range(0, 3) != 0);
      intEnable   = ($urandom_range(0, 4) != 0);
      dataBus     = W'($urandom);
      vectorReady = ($urandom_range(0, 1) != 0);
      reset       = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (INTA !== exp_inta() || vectorValid !== m_valid || busy !== exp_busy() ||
          vector !== m_vector) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: INTA=%b valid=%b busy=%b vector=%h, required %b %b %b %h",
                 i, INTA, vectorValid, busy, vector, exp_inta(), m_valid, exp_busy(), m_vector);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; INT = 0; intEnable = 0; dataBus = '0; vectorReady = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_masking();
    test_int_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
